// File: rtl/minc_pkg.sv
// Shared definitions for the minc program loader: FSM encodings, default sync
// byte and instruction ROM geometry.
package minc_pkg;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 9;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_COUNT,
    ST_LO,
    ST_HI,
    ST_CSUM,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/minc_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling timer and LSB-first
// shifter. rx_valid / rx_ferr pulse for one cycle after the stop-bit sample.
module minc_uart_rx
  import minc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic      CLK,
  input  logic      nRESET,
  input  logic      rx,
  output logic [7:0] rx_data,
  output logic      rx_valid,
  output logic      rx_ferr,
  output rx_state_e dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e      state_q, state_d;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Re-arming at the stop-bit mid-sample leaves half a bit to catch a back-to-back start edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
    endcase
  end

  assign rx_data     = shift_q;
  assign rx_valid    = valid_q;
  assign rx_ferr     = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: rtl/minc_loader.sv
// Serial program loader for the minc core: validates a framed UART image,
// writes 9-bit words into program memory and holds the core in reset meanwhile.
module minc_loader
  import minc_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [WORD_W-1:0] prog_data,
  output logic              cpu_nreset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_e            dbg_state_o,
  output rx_state_e         dbg_rx_state_o
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  minc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ferr     (rx_ferr),
    .dbg_state_o (dbg_rx_state_o)
  );

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [7:0]         lo_q, lo_d, csum_q, csum_d;
  logic               we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic               err_q, err_d, nrst_q, nrst_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nrst_q  <= nrst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    nrst_d  = nrst_q;
    // Address advances on the edge after the write strobe so it is stable during it.
    addr_d  = we_q ? addr_q + 1'b1 : addr_q;
    unique case (state_q)
      ST_SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_COUNT;
          done_d  = 1'b0;
          err_d   = 1'b0;
          csum_d  = '0;
          addr_d  = '0;
          nrst_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_ERR: state_d = ST_SYNC;
      default: begin
        if (rx_ferr || (state_q == ST_HI && rx_valid && rx_data[7:1] != 7'd0)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          nrst_d  = 1'b0;
        end else if (rx_valid) begin
          csum_d = csum_q + rx_data;
          unique case (state_q)
            ST_COUNT: begin
              cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
              state_d = ST_LO;
            end
            ST_LO: begin
              lo_d    = rx_data;
              state_d = ST_HI;
            end
            ST_HI: begin
              we_d    = 1'b1;
              data_d  = {rx_data[0], lo_q};
              cnt_d   = cnt_q - 1'b1;
              state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_LO;
            end
            default: begin
              state_d = ST_SYNC;
              busy_d  = 1'b0;
              if (rx_data == csum_q) begin
                done_d = 1'b1;
                nrst_d = 1'b1;
              end else begin
                err_d  = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  assign prog_we     = we_q;
  assign prog_addr   = addr_q;
  assign prog_data   = data_q;
  assign cpu_nreset  = nrst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/minc_loader.md
# minc_loader

Serial program loader sitting directly upstream of the minc core's 9-bit instruction ROM. Receives an 8N1 UART byte stream, validates a framed image (sync, count, word pairs, checksum), writes each 9-bit instruction into program memory through a single write port, and holds the core in reset while loading. After a good image, the core is released to run from address 0.

## Interface
- CLKS_PER_BIT, default 104: CLK cycles per UART bit; legal range is 4 and above.
- SYNC_BYTE, default 8'hA5: byte that opens a load frame.
- CLK  in  1  system clock, rising edge.
- nRESET  in  1  reset, asynchronous, active-low; clock CLK.
- rx  in  1  UART serial input, idle high, asynchronous to CLK.
- prog_we  out  1  one-cycle write strobe to program memory.
- prog_addr  out  8  write address.
- prog_data  out  9  instruction word; bit 8 = ADD/LD opcode bit.
- cpu_nreset  out  1  active-low reset to the core; 0 while loading or after a failed load.
- busy  out  1  high from the cycle after sync acceptance until the frame ends.
- done  out  1  sticky; set on a good checksum, cleared on the next sync.
- err  out  1  sticky; set on a framing, format or checksum error, cleared on the next sync.

## Operation
- rx goes through a two-flop synchronizer. The receiver detects the falling edge of the start bit and samples at mid-bit (CLKS_PER_BIT/2), then every CLKS_PER_BIT.
- If rx is high at the mid-start sample, the start bit is a glitch and the receiver returns to idle.
- Data is sent LSB first. If the stop bit samples 0, the byte is a framing error.
- Frame format: SYNC_BYTE, then COUNT (0 encodes 256 words), then COUNT × {LO, HI}, then CSUM.
  - prog_data is {HI[0], LO}.
  - HI[7:1] must be 0; otherwise it is a format error.
  - CSUM is the 8-bit wrap-around sum of COUNT and all LO and HI bytes.
- FSM states: SYNC → COUNT → LO ↔ HI → CSUM → SYNC, with ERR as the abort path.
  - SYNC: non-sync bytes are ignored. SYNC_BYTE clears done, err and the checksum, sets prog_addr=0, drives cpu_nreset=0 and sets busy.
  - COUNT: latch the word counter.
  - LO: hold the low byte.
  - HI: issue the write, increment prog_addr (wraps 255→0), decrement the counter. Go to CSUM when the counter reaches 0, else to LO.
  - CSUM: on a match, set done and release cpu_nreset. On a mismatch, set err and keep cpu_nreset=0. Return to SYNC either way.
- A framing or format error in any non-SYNC state goes to ERR: set err, clear busy, keep cpu_nreset=0, then go to SYNC.
- A framing error while in SYNC is silently ignored.
- cpu_nreset stays 0 after an error until a later frame completes with a good checksum.
- Reset values: prog_we=0, prog_addr=0, prog_data=0, cpu_nreset=1 (the preloaded image runs), busy=0, done=0, err=0, FSM=SYNC, receiver idle.
- If reset is asserted mid-frame, the frame is aborted and all outputs take their reset values. Memory contents already written remain.

## Timing
- Byte-valid pulse: 1 cycle after the stop-bit mid-sample. The FSM acts on it in the same cycle; its registered outputs update on the next edge.
- prog_we: high exactly 1 cycle, the cycle after the HI byte-valid pulse. prog_addr and prog_data are stable during that cycle. prog_addr increments on the following edge.
- cpu_nreset falls 1 cycle after the SYNC_BYTE valid pulse.
- On a good checksum, cpu_nreset rises 1 cycle after the CSUM valid pulse; done rises and busy falls in that same cycle.
- Back-to-back bytes with no idle bit between them are accepted. The receiver re-arms on the stop-bit mid-sample.
- No flow control: every byte is consumed within 1 cycle of its valid pulse, so no byte is ever dropped.

## Structure
- Shared package/header minc_pkg holds:
  - FSM state encodings (SYNC, COUNT, LO, HI, CSUM, ERR);
  - the default SYNC_BYTE;
  - ROM geometry constants: 8-bit address, 9-bit word.
- One sub-module, minc_uart_rx, containing the synchronizer, bit timer and shifter. It outputs rx_data[7:0], rx_valid and rx_ferr.
- The top level holds the frame FSM, the checksum and the address and word counters.

## Test plan
- Run with CLKS_PER_BIT=16.
  - Stimulus: A5 02 34 01 12 00 49.
  - Required response: writes (0,0x134) and (1,0x012); done=1; err=0; cpu_nreset rises 1 cycle after CSUM.
- Same frame with CSUM=0x48 → both writes still occur; err=1, done=0, cpu_nreset stays 0. A following good frame → cpu_nreset=1.
- Noise and glitches:
  - Stimulus: bytes 00 FF 5A before A5, plus a 3-cycle low glitch on rx.
  - Required response: no writes, cpu_nreset stays 1; the subsequent frame loads normally.
- HI byte 0x03 → err=1 at that byte, no write for that word, busy=0, FSM back in SYNC.
- Full image:
  - Stimulus: COUNT=00 followed by 256 words with data=addr.
  - Required response: 256 writes with addresses 0..255; prog_addr wraps to 0; correct checksum gives done=1.
- Reset mid-frame:
  - Stimulus: pulse nRESET low after the 3rd word.
  - Required response: all outputs return to reset values (cpu_nreset=1, prog_addr=0); no further writes until a new A5.
